// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
// Shared definitions for the GPIO input conditioning block:
//   - default pin count and debounce length
//   - debounce counter width helper
//   - per-pin control bundle (edge enables and clear strobe)
// Configuration macro: GPIO_IN_DEBOUNCE_EN (selects debounce vs. direct path).
// -----------------------------------------------------------------------------
package gpio_pkg;

  localparam int unsigned NPINS_DEF     = 20;
  localparam int unsigned DB_CYCLES_DEF = 16;

  // Width needed to hold DB_CYCLES-1 (the terminal count), at least one bit.
  function automatic int unsigned cnt_width(input int unsigned db_cycles);
    int unsigned w;
    if (db_cycles <= 32'd2) begin
      w = 32'd1;
    end else begin
      w = $clog2(db_cycles);
    end
    return w;
  endfunction

  localparam int unsigned DB_CNT_W_DEF = cnt_width(DB_CYCLES_DEF);

  // Per-pin interrupt controls as seen by one pin slice.
  typedef struct packed {
    logic rise_en;
    logic fall_en;
    logic clr;
  } pin_ctrl_t;

endpackage

// File: rtl/gpio_in_pin.sv
// -----------------------------------------------------------------------------
// gpio_in_pin
// One GPIO input slice: two-flop synchronizer, optional debounce counter,
// clean level flop and sticky edge-event status flop.
// Configuration macro: GPIO_IN_DEBOUNCE_EN
//   defined   : clean level follows the synchronizer only after DB_CYCLES
//               consecutive differing samples
//   undefined : clean level reloads from the synchronizer every edge
// Ports:
//   clock    - rising-edge clock
//   rst      - synchronous active-high reset
//   raw_i    - asynchronous pad input
//   ctrl_i   - rise/fall enables and write-1-to-clear strobe
//   clean_o  - synchronized (and debounced) level
//   status_o - sticky edge-event flag
// -----------------------------------------------------------------------------
module gpio_in_pin
  import gpio_pkg::*;
`ifdef GPIO_IN_DEBOUNCE_EN
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
)
`endif
(
  input  logic      clock,
  input  logic      rst,
  input  logic      raw_i,
  input  pin_ctrl_t ctrl_i,
  output logic      clean_o,
  output logic      status_o
);

  logic s1_q;
  logic s2_q;
  logic clean_q;
  logic clean_d;
  logic status_q;
  logic status_d;
  logic rise_s;
  logic fall_s;

  // Two-flop synchronizer, no logic between the stages.
  always_ff @(posedge clock) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int unsigned CNT_W = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 32'd1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Debounce: count consecutive cycles where the synchronized level differs
  // from the clean level; accept the new level on the edge after the count
  // has reached its terminal value. Any agreeing sample restarts the count.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    if (s2_q != clean_q) begin
      if (cnt_q == CNT_MAX) begin
        clean_d = s2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Debounce counter register.
  always_ff @(posedge clock) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Direct path: clean level tracks the synchronizer output every edge.
  always_comb begin
    clean_d = s2_q;
  end
`endif

  // Edge events are taken from the clean level change itself, so the status
  // flag sets on the very edge the clean level moves. A set beats a clear.
  always_comb begin
    rise_s   = clean_d & ~clean_q & ctrl_i.rise_en;
    fall_s   = ~clean_d & clean_q & ctrl_i.fall_en;
    status_d = status_q;
    if (rise_s || fall_s) begin
      status_d = 1'b1;
    end else if (ctrl_i.clr) begin
      status_d = 1'b0;
    end else begin
      status_d = status_q;
    end
  end

  // Clean level and sticky status registers.
  always_ff @(posedge clock) begin
    if (rst) begin
      clean_q  <= 1'b0;
      status_q <= 1'b0;
    end else begin
      clean_q  <= clean_d;
      status_q <= status_d;
    end
  end

  assign clean_o  = clean_q;
  assign status_o = status_q;

endmodule

// File: rtl/gpio_in_cond.sv
// -----------------------------------------------------------------------------
// gpio_in_cond
// GPIO input conditioning: per-pin synchronizer, debounce, edge detection and
// sticky interrupt status, with a single OR-reduced interrupt request.
// Configuration macro: GPIO_IN_DEBOUNCE_EN (debounce enabled when defined;
// otherwise DB_CYCLES is ignored and the clean path has 3-edge latency).
// Parameters:
//   NPINS     - number of GPIO input pins
//   DB_CYCLES - consecutive stable cycles before a clean level change (2..255)
// Ports:
//   clock       - sole clock, rising edge
//   rst         - synchronous active-high reset
//   gpi_raw     - asynchronous pad inputs
//   gpi_clean   - synchronized, debounced levels
//   rise_en     - per-pin rising-edge interrupt enable
//   fall_en     - per-pin falling-edge interrupt enable
//   intr_clr    - per-pin write-1-to-clear strobe
//   intr_status - per-pin sticky edge-event flags
//   gpio_intr   - OR of intr_status
// -----------------------------------------------------------------------------
module gpio_in_cond
  import gpio_pkg::*;
#(
  parameter int unsigned NPINS     = NPINS_DEF,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
)
(
  input  logic             clock,
  input  logic             rst,
  input  logic [NPINS-1:0] gpi_raw,
  output logic [NPINS-1:0] gpi_clean,
  input  logic [NPINS-1:0] rise_en,
  input  logic [NPINS-1:0] fall_en,
  input  logic [NPINS-1:0] intr_clr,
  output logic [NPINS-1:0] intr_status,
  output logic             gpio_intr
);

  // Reject an unsupported debounce length at elaboration.
  if ((DB_CYCLES < 32'd2) || (DB_CYCLES > 32'd255)) begin : g_db_range_check
    $error("gpio_in_cond: DB_CYCLES must be within 2..255");
  end

  for (genvar i = 0; i < NPINS; i++) begin : g_pin
    pin_ctrl_t ctrl_s;

    assign ctrl_s.rise_en = rise_en[i];
    assign ctrl_s.fall_en = fall_en[i];
    assign ctrl_s.clr     = intr_clr[i];

`ifdef GPIO_IN_DEBOUNCE_EN
    gpio_in_pin #(
      .DB_CYCLES (DB_CYCLES)
    ) u_pin (
      .clock    (clock),
      .rst      (rst),
      .raw_i    (gpi_raw[i]),
      .ctrl_i   (ctrl_s),
      .clean_o  (gpi_clean[i]),
      .status_o (intr_status[i])
    );
`else
    gpio_in_pin u_pin (
      .clock    (clock),
      .rst      (rst),
      .raw_i    (gpi_raw[i]),
      .ctrl_i   (ctrl_s),
      .clean_o  (gpi_clean[i]),
      .status_o (intr_status[i])
    );
`endif
  end

  assign gpio_intr = |intr_status;

endmodule

// File: tb/tb_gpio_in_cond.sv
module tb_gpio_in_cond;

  localparam int NP = 20;
  localparam int DB = 16;
`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int WIN = DB;
`else
  localparam int WIN = 1;
`endif
  // Edges from first capturing edge to clean level change.
  localparam int LAT = WIN + 2;

  typedef logic [NP-1:0] vec_t;

  logic clock = 1'b0;
  logic rst;
  vec_t gpi_raw, rise_en, fall_en, intr_clr;
  vec_t gpi_clean, intr_status;
  logic gpio_intr;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  gpio_in_cond #(
    .NPINS     (NP),
    .DB_CYCLES (DB)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .gpi_raw     (gpi_raw),
    .gpi_clean   (gpi_clean),
    .rise_en     (rise_en),
    .fall_en     (fall_en),
    .intr_clr    (intr_clr),
    .intr_status (intr_status),
    .gpio_intr   (gpio_intr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A clean level flips on edge t when every synchronized sample seen on the
  // last WIN edges differed from it and none of those edges was a reset.
  vec_t m_clean = '0;
  vec_t m_stat  = '0;
  vec_t m_raw_prev = '0;
  vec_t m_w_prev = '0;
  logic m_rst_prev = 1'b1;
  vec_t win_w[$];
  logic win_r[$];
  bit   chk_model = 1'b0;

  task automatic model_edge();
    vec_t w_cur, flip, nclean, rise, fall;
    w_cur = (rst || m_rst_prev) ? '0 : m_raw_prev;
    win_w.push_back(m_w_prev);
    win_r.push_back(rst);
    while (win_w.size() > WIN) begin
      win_w.delete(0);
      win_r.delete(0);
    end
    if (rst) begin
      nclean = '0;
    end else begin
      flip = (win_w.size() < WIN) ? '0 : '1;
      for (int k = 0; k < win_w.size(); k++) begin
        if (win_r[k]) flip = '0;
        flip &= (win_w[k] ^ m_clean);
      end
      nclean = m_clean ^ flip;
    end
    rise = nclean & ~m_clean & rise_en;
    fall = ~nclean & m_clean & fall_en;
    m_stat = rst ? '0 : (rise | fall | (m_stat & ~intr_clr));
    m_clean = nclean;
    m_rst_prev = rst;
    m_raw_prev = gpi_raw;
    m_w_prev = w_cur;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    if (chk_model) begin
      check("model_clean", 32'(gpi_clean), 32'(m_clean));
      check("model_status", 32'(intr_status), 32'(m_stat));
      check("model_intr", 32'(gpio_intr), 32'(|m_stat));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; gpi_raw = '0; rise_en = '0; fall_en = '0; intr_clr = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string name;
    logic  rst;
    vec_t  raw, rise, fall, clr;
    int    cyc;
    vec_t  exp_clean, exp_stat;
    logic  exp_intr;
  } vec_rec_t;

  vec_rec_t tbl[11];

  function automatic vec_rec_t mk(input string n, input logic r, input vec_t raw, input vec_t ri,
                                  input vec_t fa, input vec_t cl, input int cyc,
                                  input vec_t ec, input vec_t es, input logic ei);
    vec_rec_t v;
    v.name = n; v.rst = r; v.raw = raw; v.rise = ri; v.fall = fa; v.clr = cl;
    v.cyc = cyc; v.exp_clean = ec; v.exp_stat = es; v.exp_intr = ei;
    return v;
  endfunction

  initial begin
    int  gw;
    logic saw;
    vec_t one, all;
    one = 20'h00001;
    all = 20'hFFFFF;
    rst = 1'b1; gpi_raw = '0; rise_en = '0; fall_en = '0; intr_clr = '0;

    tbl[0]  = mk("reset",         1'b1, '0,  '0,  '0, '0,  2,       '0,  '0,  1'b0);
    tbl[1]  = mk("rise_pre",      1'b0, one, one, '0, '0,  LAT - 1, '0,  '0,  1'b0);
    tbl[2]  = mk("rise_lat",      1'b0, one, one, '0, '0,  1,       one, one, 1'b1);
    tbl[3]  = mk("clr0",          1'b0, one, one, '0, one, 1,       one, '0,  1'b0);
    tbl[4]  = mk("fall_masked",   1'b0, '0,  one, '0, '0,  LAT,     '0,  '0,  1'b0);
    tbl[5]  = mk("all_pre",       1'b0, all, all, '0, '0,  LAT - 1, '0,  '0,  1'b0);
    tbl[6]  = mk("all_rise",      1'b0, all, all, '0, '0,  1,       all, all, 1'b1);
    tbl[7]  = mk("en_off_keeps",  1'b0, all, '0,  '0, '0,  3,       all, all, 1'b1);
    tbl[8]  = mk("clr_all",       1'b0, all, '0,  '0, all, 1,       all, '0,  1'b0);
    tbl[9]  = mk("rst_clears",    1'b1, all, all, '0, '0,  1,       '0,  '0,  1'b0);
    tbl[10] = mk("rst_rel_rise",  1'b0, all, all, '0, '0,  LAT,     all, all, 1'b1);

    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; gpi_raw = tbl[i].raw; rise_en = tbl[i].rise;
      fall_en = tbl[i].fall; intr_clr = tbl[i].clr;
      repeat (tbl[i].cyc) tick();
      check({tbl[i].name, "_clean"}, 32'(gpi_clean), 32'(tbl[i].exp_clean));
      check({tbl[i].name, "_stat"}, 32'(intr_status), 32'(tbl[i].exp_stat));
      check({tbl[i].name, "_intr"}, 32'(gpio_intr), 32'(tbl[i].exp_intr));
    end
    intr_clr = '0;

    // Glitch on pin 3: rejected with debounce, passes straight through without.
`ifdef GPIO_IN_DEBOUNCE_EN
    gw = 10;
`else
    gw = 1;
`endif
    do_reset();
    rise_en = all;
    gpi_raw[3] = 1'b1;
    repeat (gw) tick();
    gpi_raw[3] = 1'b0;
    saw = 1'b0;
    repeat (30) begin
      tick();
      saw |= gpi_clean[3];
    end
`ifdef GPIO_IN_DEBOUNCE_EN
    check("glitch_clean3", 32'(saw), 32'd0);
    check("glitch_stat", 32'(intr_status), 32'd0);
`else
    check("glitch_pass3", 32'(saw), 32'd1);
    check("glitch_stat3", 32'(intr_status[3]), 32'd1);
`endif
    // A real transition afterwards needs the full latency (count restarted).
    gpi_raw[3] = 1'b1;
    repeat (LAT - 1) tick();
    check("relat_pre3", 32'(gpi_clean[3]), 32'd0);
    tick();
    check("relat_at3", 32'(gpi_clean[3]), 32'd1);

    // Pin 5 falling edge with a clear on the same edge as the set.
    do_reset();
    fall_en[5] = 1'b1;
    gpi_raw[5] = 1'b1;
    repeat (LAT) tick();
    check("p5_high_clean", 32'(gpi_clean[5]), 32'd1);
    check("p5_rise_masked", 32'(intr_status), 32'd0);
    gpi_raw[5] = 1'b0;
    repeat (LAT - 1) tick();
    intr_clr[5] = 1'b1;
    tick();
    intr_clr = '0;
    check("p5_set_wins", 32'(intr_status), 32'h20);
    check("p5_fall_clean", 32'(gpi_clean[5]), 32'd0);
    check("p5_intr", 32'(gpio_intr), 32'd1);
    tick();
    check("p5_sticky", 32'(intr_status[5]), 32'd1);
    intr_clr[5] = 1'b1;
    tick();
    intr_clr = '0;
    check("p5_cleared", 32'(intr_status[5]), 32'd0);
    check("p5_intr_off", 32'(gpio_intr), 32'd0);

    // Reset in the middle of a debounce on pin 2.
    do_reset();
    rise_en[2] = 1'b1;
    gpi_raw[2] = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("p2_rst_clean", 32'(gpi_clean), 32'd0);
    check("p2_rst_stat", 32'(intr_status), 32'd0);
    repeat (LAT - 1) tick();
    check("p2_restart_pre", 32'(gpi_clean[2]), 32'd0);
    tick();
    check("p2_restart_at", 32'(gpi_clean[2]), 32'd1);
    check("p2_restart_stat", 32'(intr_status[2]), 32'd1);

    // Randomized run against the reference model.
    do_reset();
    chk_model = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(19, 0) == 0) gpi_raw[p] = ~gpi_raw[p];
      end
      if ($urandom_range(199, 0) == 0) rise_en = vec_t'($urandom);
      if ($urandom_range(199, 0) == 0) fall_en = vec_t'($urandom);
      intr_clr = vec_t'($urandom & $urandom & $urandom & $urandom);
      rst = ($urandom_range(499, 0) == 0);
      tick();
    end
    chk_model = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
